// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: shadow EXE/MEM destinations, operand forwarding
// selects, load-use and mul/div stalls, and redirect flush control.
//
// Ports:
//   clk, resetn                      clock, async active-low reset
//   idValid, idRs1, idRs2            ID instruction valid and source addresses
//   idUse1, idUse2                   source is actually read
//   idRd, idWreg                     ID destination and regfile write enable
//   idLoad, idMulDiv                 ID instruction class
//   exRedirect                       taken branch/jump resolved in EXE
//   qaSel, qbSel                     operand source: 0 regfile, 1 EXE, 2 MEM
//   pcStall, ifidStall               hold PC and IF/ID
//   ifidFlush, idexFlush             squash IF/ID, bubble into ID/EX
//   mdBusy, mdWe, mdRd               mul/div occupancy, writeback pulse, dest
module hazard_scoreboard #(
    parameter int NREGS = 32,
    parameter int MDLAT = 4,
    parameter int FWD_MEM = 1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          idValid,
    input  logic [AW-1:0] idRs1,
    input  logic [AW-1:0] idRs2,
    input  logic          idUse1,
    input  logic          idUse2,
    input  logic [AW-1:0] idRd,
    input  logic          idWreg,
    input  logic          idLoad,
    input  logic          idMulDiv,
    input  logic          exRedirect,
    output logic [1:0]    qaSel,
    output logic [1:0]    qbSel,
    output logic          pcStall,
    output logic          ifidStall,
    output logic          ifidFlush,
    output logic          idexFlush,
    output logic          mdBusy,
    output logic          mdWe,
    output logic [AW-1:0] mdRd
);

    localparam logic       FWD = (FWD_MEM != 0);
    localparam logic [3:0] MDL = 4'(MDLAT);

    logic [AW-1:0] exRd, memRd, mdRdQ;
    logic          exWreg, exLoad, memWreg, mdWregQ;
    logic [3:0]    mdCnt;

    logic src1, src2;
    logic exHit1, exHit2, memHit1, memHit2;
    logic mdHit1, mdHit2, wawHit;
    logic mdStall, luStall, issue;

    // Address 0 is excluded at the source so it never matches anything.
    assign src1 = idUse1 && (idRs1 != '0);
    assign src2 = idUse2 && (idRs2 != '0);

    assign exHit1  = src1 && exWreg && (exRd == idRs1);
    assign exHit2  = src2 && exWreg && (exRd == idRs2);
    assign memHit1 = src1 && memWreg && (memRd == idRs1);
    assign memHit2 = src2 && memWreg && (memRd == idRs2);
    assign mdHit1  = src1 && (idRs1 == mdRdQ);
    assign mdHit2  = src2 && (idRs2 == mdRdQ);
    assign wawHit  = idWreg && (idRd != '0) && (idRd == mdRdQ);

    assign mdBusy = (mdCnt != 4'd0);
    assign mdWe   = (mdCnt == 4'd1) && mdWregQ;
    assign mdRd   = mdRdQ;

    assign mdStall = idValid && mdBusy &&
                     (idMulDiv || mdHit1 || mdHit2 || wawHit);

    // A load in EXE has no data yet; without MEM forwarding a MEM
    // producer must also wait one cycle for writeback.
    assign luStall = idValid &&
                     ((exLoad && (exHit1 || exHit2)) ||
                      (!FWD && (memHit1 || memHit2)));

    function automatic logic [1:0] fwdSel(input logic exh, input logic memh);
        logic [1:0] s;
        s = 2'd0;
        if (exh && !exLoad)
            s = 2'd1;
        else if (FWD && memh)
            s = 2'd2;
        return s;
    endfunction

    always_comb begin
        qaSel = 2'd0;
        qbSel = 2'd0;
        if (idValid) begin
            qaSel = fwdSel(exHit1, memHit1);
            qbSel = fwdSel(exHit2, memHit2);
        end
    end

    // Redirect overrides every stall; stalls override issue.
    always_comb begin
        pcStall   = 1'b0;
        ifidStall = 1'b0;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        issue     = 1'b0;
        if (exRedirect) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (mdStall || luStall) begin
            pcStall   = 1'b1;
            ifidStall = 1'b1;
            idexFlush = 1'b1;
        end else begin
            issue = idValid;
        end
    end

    // Shadow EXE/MEM stages; mul/div never enters the shadow EXE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exRd    <= '0;
            exWreg  <= 1'b0;
            exLoad  <= 1'b0;
            memRd   <= '0;
            memWreg <= 1'b0;
        end else begin
            memRd   <= exRd;
            memWreg <= exWreg;
            if (issue && !idMulDiv) begin
                exRd   <= idRd;
                exWreg <= idWreg;
                exLoad <= idLoad;
            end else begin
                exRd   <= '0;
                exWreg <= 1'b0;
                exLoad <= 1'b0;
            end
        end
    end

    // Mul/div tracker: a redirect only blocks a new issue, it never
    // cancels a tracked operation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mdCnt   <= 4'd0;
            mdRdQ   <= '0;
            mdWregQ <= 1'b0;
        end else if (issue && idMulDiv) begin
            mdCnt   <= MDL;
            mdRdQ   <= idRd;
            mdWregQ <= idWreg;
        end else if (mdCnt != 4'd0) begin
            mdCnt <= mdCnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: unit A forwards from MEM,
// unit B (FWD_MEM=0) shares its inputs and is checked on marked rows.
module tb_hazard_scoreboard;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       idValid, idUse1, idUse2, idWreg, idLoad, idMulDiv, exRedirect;
    logic [4:0] idRs1, idRs2, idRd;

    logic [1:0] aQa, aQb, bQa, bQb;
    logic       aPc, aIfs, aIfl, aIxf, aBusy, aWe;
    logic       bPc, bIfs, bIfl, bIxf, bBusy, bWe;
    logic [4:0] aMdRd, bMdRd;

    hazard_scoreboard #(.NREGS(32), .MDLAT(4), .FWD_MEM(1)) dutA (
        .clk(clk), .resetn(resetn), .idValid(idValid),
        .idRs1(idRs1), .idRs2(idRs2), .idUse1(idUse1), .idUse2(idUse2),
        .idRd(idRd), .idWreg(idWreg), .idLoad(idLoad), .idMulDiv(idMulDiv),
        .exRedirect(exRedirect), .qaSel(aQa), .qbSel(aQb),
        .pcStall(aPc), .ifidStall(aIfs), .ifidFlush(aIfl), .idexFlush(aIxf),
        .mdBusy(aBusy), .mdWe(aWe), .mdRd(aMdRd)
    );

    hazard_scoreboard #(.NREGS(32), .MDLAT(4), .FWD_MEM(0)) dutB (
        .clk(clk), .resetn(resetn), .idValid(idValid),
        .idRs1(idRs1), .idRs2(idRs2), .idUse1(idUse1), .idUse2(idUse2),
        .idRd(idRd), .idWreg(idWreg), .idLoad(idLoad), .idMulDiv(idMulDiv),
        .exRedirect(exRedirect), .qaSel(bQa), .qbSel(bQb),
        .pcStall(bPc), .ifidStall(bIfs), .ifidFlush(bIfl), .idexFlush(bIxf),
        .mdBusy(bBusy), .mdWe(bWe), .mdRd(bMdRd)
    );

    typedef struct packed {
        logic       rn, v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       w, ld, md, rdr;
        logic [1:0] qa, qb;
        logic       stl, ifl, ixf, bsy, we;
        logic [4:0] mrd;
        logic       c0;
        logic [1:0] qb0;
        logic       stl0;
    } vec_t;

    vec_t q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   row = 0;

    function automatic vec_t mk(
        input logic rn, input logic v,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic u1, input logic u2, input logic [4:0] rd,
        input logic w, input logic ld, input logic md, input logic rdr,
        input logic [1:0] qa, input logic [1:0] qb,
        input logic stl, input logic ifl, input logic ixf,
        input logic bsy, input logic we, input logic [4:0] mrd);
        vec_t t;
        t = '{rn, v, rs1, rs2, u1, u2, rd, w, ld, md, rdr,
              qa, qb, stl, ifl, ixf, bsy, we, mrd, F, 2'd0, F};
        return t;
    endfunction

    function automatic vec_t nop(input logic rn, input logic bsy,
                                 input logic we, input logic [4:0] mrd);
        return mk(rn, F, 5'd0, 5'd0, F, F, 5'd0, F, F, F, F,
                  2'd0, 2'd0, F, F, F, bsy, we, mrd);
    endfunction

    function automatic vec_t withB(input vec_t t, input logic [1:0] qb0,
                                   input logic stl0);
        vec_t r;
        r = t;
        r.c0 = T;
        r.qb0 = qb0;
        r.stl0 = stl0;
        return r;
    endfunction

    task automatic drive(input vec_t t);
        @(posedge clk);
        #1;
        resetn     = t.rn;
        idValid    = t.v;
        idRs1      = t.rs1;
        idRs2      = t.rs2;
        idUse1     = t.u1;
        idUse2     = t.u2;
        idRd       = t.rd;
        idWreg     = t.w;
        idLoad     = t.ld;
        idMulDiv   = t.md;
        exRedirect = t.rdr;
        q.push_back(t);
    endtask

    always @(negedge clk) begin
        vec_t e;
        logic [14:0] act, exp;
        logic [4:0] actB, expB;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {aQa, aQb, aPc, aIfs, aIfl, aIxf, aBusy, aWe, aMdRd};
            exp = {e.qa, e.qb, e.stl, e.stl, e.ifl, e.ixf, e.bsy, e.we, e.mrd};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL row %0d unitA got %h want %h", row, act, exp);
            end
            if (e.c0) begin
                actB = {bQb, bPc, bIfs, bIxf};
                expB = {e.qb0, e.stl0, e.stl0, e.stl0};
                checks++;
                if (actB !== expB) begin
                    errors++;
                    $display("FAIL row %0d unitB got %h want %h",
                             row, actB, expB);
                end
            end
            row++;
        end
    end

    initial begin
        vec_t addX7, mulX9;
        resetn = 1'b1;
        idValid = F; idUse1 = F; idUse2 = F; idWreg = F;
        idLoad = F; idMulDiv = F; exRedirect = F;
        idRs1 = 5'd0; idRs2 = 5'd0; idRd = 5'd0;
        #1 resetn = 1'b0;

        // Active instruction held during reset must see cleared state.
        drive(mk(F, T, 5'd5, 5'd5, T, T, 5'd5, T, T, T, F,
                 2'd0, 2'd0, F, F, F, F, F, 5'd0));
        drive(mk(F, T, 5'd5, 5'd5, T, T, 5'd5, T, T, T, F,
                 2'd0, 2'd0, F, F, F, F, F, 5'd0));

        // add x5 ; sub x6,x5 ; gap ; use x6 from MEM
        tbl.push_back(mk(T, T, 5'd1, 5'd2, T, T, 5'd5, T, F, F, F,
                         2'd0, 2'd0, F, F, F, F, F, 5'd0));
        tbl.push_back(mk(T, T, 5'd5, 5'd3, T, T, 5'd6, T, F, F, F,
                         2'd1, 2'd0, F, F, F, F, F, 5'd0));
        tbl.push_back(mk(T, F, 5'd6, 5'd5, T, T, 5'd0, F, F, F, F,
                         2'd0, 2'd0, F, F, F, F, F, 5'd0));
        tbl.push_back(mk(T, T, 5'd6, 5'd0, T, T, 5'd0, F, F, F, F,
                         2'd2, 2'd0, F, F, F, F, F, 5'd0));
        tbl.push_back(nop(T, F, F, 5'd0));
        // lw x7 ; add rs2=x7
        addX7 = mk(T, T, 5'd2, 5'd7, T, T, 5'd8, T, F, F, F,
                   2'd0, 2'd0, T, F, T, F, F, 5'd0);
        tbl.push_back(mk(T, T, 5'd1, 5'd0, T, F, 5'd7, T, T, F, F,
                         2'd0, 2'd0, F, F, F, F, F, 5'd0));
        tbl.push_back(addX7);
        addX7.qb = 2'd2; addX7.stl = F; addX7.ixf = F;
        tbl.push_back(addX7);
        tbl.push_back(nop(T, F, F, 5'd0));
        // x0 producers (including a load) never create hazards
        tbl.push_back(mk(T, T, 5'd1, 5'd2, T, T, 5'd0, T, F, F, F,
                         2'd0, 2'd0, F, F, F, F, F, 5'd0));
        tbl.push_back(mk(T, T, 5'd0, 5'd0, T, T, 5'd0, T, T, F, F,
                         2'd0, 2'd0, F, F, F, F, F, 5'd0));
        tbl.push_back(mk(T, T, 5'd0, 5'd0, T, T, 5'd3, T, F, F, F,
                         2'd0, 2'd0, F, F, F, F, F, 5'd0));
        tbl.push_back(nop(T, F, F, 5'd0));
        // mul x9 ; dependent add waits for writeback
        tbl.push_back(mk(T, T, 5'd1, 5'd2, T, T, 5'd9, T, F, T, F,
                         2'd0, 2'd0, F, F, F, F, F, 5'd0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(T, T, 5'd9, 5'd3, T, T, 5'd10, T, F, F, F,
                             2'd0, 2'd0, T, F, T, T, (i == 3), 5'd9));
        tbl.push_back(mk(T, T, 5'd9, 5'd3, T, T, 5'd10, T, F, F, F,
                         2'd0, 2'd0, F, F, F, F, F, 5'd9));
        tbl.push_back(nop(T, F, F, 5'd9));
        // mul x11 ; independent adds flow ; WAW meets redirect
        tbl.push_back(mk(T, T, 5'd1, 5'd2, T, T, 5'd11, T, F, T, F,
                         2'd0, 2'd0, F, F, F, F, F, 5'd9));
        tbl.push_back(mk(T, T, 5'd3, 5'd4, T, T, 5'd12, T, F, F, F,
                         2'd0, 2'd0, F, F, F, T, F, 5'd11));
        tbl.push_back(mk(T, T, 5'd12, 5'd0, T, F, 5'd13, T, F, F, F,
                         2'd1, 2'd0, F, F, F, T, F, 5'd11));
        tbl.push_back(mk(T, T, 5'd1, 5'd2, T, T, 5'd11, T, F, F, T,
                         2'd0, 2'd0, F, T, T, T, F, 5'd11));
        tbl.push_back(nop(T, T, T, 5'd11));
        tbl.push_back(nop(T, F, F, 5'd11));
        // lw x14 ; redirect beats the load-use stall
        tbl.push_back(mk(T, T, 5'd1, 5'd0, T, F, 5'd14, T, T, F, F,
                         2'd0, 2'd0, F, F, F, F, F, 5'd11));
        tbl.push_back(mk(T, T, 5'd14, 5'd0, T, F, 5'd15, T, F, F, T,
                         2'd0, 2'd0, F, T, T, F, F, 5'd11));
        for (int i = 0; i < 6; i++)
            tbl.push_back(nop(T, F, F, 5'd11));
        // lw x7 ; add x7 on both units
        tbl.push_back(withB(mk(T, T, 5'd1, 5'd0, T, F, 5'd7, T, T, F, F,
                               2'd0, 2'd0, F, F, F, F, F, 5'd11), 2'd0, F));
        addX7.mrd = 5'd11;
        addX7.qb = 2'd0; addX7.stl = T; addX7.ixf = T;
        tbl.push_back(withB(addX7, 2'd0, T));
        addX7.qb = 2'd2; addX7.stl = F; addX7.ixf = F;
        tbl.push_back(withB(addX7, 2'd0, T));
        addX7.qb = 2'd0;
        tbl.push_back(withB(addX7, 2'd0, F));
        tbl.push_back(nop(T, F, F, 5'd11));

        for (int i = 0; i < tbl.size(); i++)
            drive(tbl[i]);

        // Reset lands while the mul/div counter reads 2.
        mulX9 = mk(T, T, 5'd1, 5'd2, T, T, 5'd9, T, F, T, F,
                   2'd0, 2'd0, F, F, F, F, F, 5'd11);
        drive(mulX9);
        drive(nop(T, T, F, 5'd9));
        drive(nop(T, T, F, 5'd9));
        drive(nop(F, F, F, 5'd0));
        drive(nop(F, F, F, 5'd0));
        for (int i = 0; i < 6; i++)
            drive(nop(T, F, F, 5'd0));
        // Issue right after release and forward from it.
        drive(mk(T, T, 5'd1, 5'd2, T, T, 5'd5, T, F, F, F,
                 2'd0, 2'd0, F, F, F, F, F, 5'd0));
        drive(mk(T, T, 5'd5, 5'd5, T, T, 5'd6, T, F, F, F,
                 2'd1, 2'd1, F, F, F, F, F, 5'd0));

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREGS, default 32: architectural register count; AW = clog2(NREGS) address width.
REQ-002 Parameter MDLAT, default 4, legal 2..15: mul/div latency in cycles from issue to writeback.
REQ-003 Parameter FWD_MEM, default 1: 1 enables MEM-stage forwarding; 0 stalls instead.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 idValid  in  1  valid instruction in ID.
REQ-007 idRs1, idRs2  in  AW each  ID source addresses.
REQ-008 idUse1, idUse2  in  1 each  source actually read.
REQ-009 idRd  in  AW  ID destination; idWreg  in  1  ID writes regfile.
REQ-010 idLoad, idMulDiv  in  1 each  ID instruction class.
REQ-011 exRedirect  in  1  branch/jump resolved taken in EXE this cycle.
REQ-012 qaSel, qbSel  out  2 each  0=regfile, 1=EXE result, 2=MEM result.
REQ-013 pcStall, ifidStall  out  1 each  hold PC and IF/ID register.
REQ-014 ifidFlush, idexFlush  out  1 each  squash IF/ID; insert bubble into ID/EX.
REQ-015 mdBusy  out  1  mul/div unit occupied; mdWe  out  1  mul/div writeback pulse; mdRd  out  AW  its destination.

Function
REQ-016 Block SHALL hold shadow stage registers exRd/exWreg/exLoad and memRd/memWreg, advanced every cycle; EXE receives ID fields when ID issues, else a bubble (Wreg=0).
REQ-017 ID "issues" when idValid=1 and pcStall=0 and exRedirect=0; mul/div instructions issue to the mul/div tracker, not to shadow EXE (exWreg=0 for them).
REQ-018 Address 0 SHALL never match any hazard or forwarding comparison.
REQ-019 Forwarding (combinational): qaSel=1 if idUse1 and exWreg and exRd==idRs1 and not exLoad; else 2 if FWD_MEM and memWreg and memRd==idRs1; else 0. qbSel identical on Rs2; EXE beats MEM.
REQ-020 Load-use: source match on EXE with exLoad=1 SHALL stall 1 cycle (pcStall=ifidStall=idexFlush=1); next cycle the load is in MEM and forwards with qaSel/qbSel=2.
REQ-021 FWD_MEM=0: MEM match SHALL stall 1 cycle like REQ-020.
REQ-022 Mul/div tracker: counter loads MDLAT at issue, decrements to 0; mdBusy = counter!=0; mdWe=1 when counter==1 and tracked Wreg=1; mdRd holds tracked rd.
REQ-023 While mdBusy, stall ID if it is a mul/div, or a source matches mdRd, or idWreg and idRd==mdRd (WAW); stall released the cycle after mdWe.
REQ-024 Redirect priority: exRedirect=1 SHALL force ifidFlush=idexFlush=1, pcStall=ifidStall=0, overriding every stall; the ID instruction does not issue.
REQ-025 Redirect SHALL NOT cancel an in-flight mul/div (issued in an older cycle).
REQ-026 Priority: redirect > mul/div stall > load-use/MEM stall > issue; stalls assert pcStall, ifidStall, idexFlush together.
REQ-027 idValid=0: no stall, no issue, qaSel=qbSel=0.

Reset
REQ-028 resetn low SHALL asynchronously clear all shadow stages, counter and tracked rd; outputs: qaSel=qbSel=0, stall/flush=0, mdBusy=mdWe=0, mdRd=0.
REQ-029 Reset asserted mid mul/div SHALL abandon it with no mdWe pulse after release.
REQ-030 First issue permitted in the first clk edge after resetn rises.

Verification
REQ-031 add x5 then sub using x5 next cycle -> qaSel=1, no stall; one gap cycle -> qaSel=2.
REQ-032 lw x7 then add rs2=x7 -> one stall cycle (pcStall=idexFlush=1), then qbSel=2; with FWD_MEM=0 -> two stall cycles, then qbSel=0.
REQ-033 mul x9 (MDLAT=4) then add using x9 -> mdBusy 4 cycles, mdWe in cycle 4 with mdRd=9, add issues cycle 5, qaSel=0; independent add issues immediately.
REQ-034 exRedirect=1 concurrent with load-use hazard -> flushes=1, pcStall=0; mul/div in flight still produces mdWe.
REQ-035 Instruction writing/reading x0 after any producer to x0 -> qaSel=qbSel=0, no stall.
REQ-036 resetn pulled low at counter=2 -> mdBusy=0 immediately, no mdWe afterwards, all outputs at reset values.
